i2s_stereo_transmitter: RTL

- Consumes the interleaved stereo valid/ready sample stream produced by the echo effect's serializer output (is_left-tagged samples) and drives a standard Philips I2S master output: bit clock, word select, serial data.
- Sits at the DAC end of the audio path.
- Holds one pending sample per channel and emits frames continuously. A missing sample is an underrun: silence is transmitted and flagged.

---
 rtl/i2s_stereo_transmitter_pkg.sv | 27 ++
 rtl/i2s_stereo_transmitter_sclk_divider.sv | 56 +++++
 rtl/i2s_stereo_transmitter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/i2s_stereo_transmitter_pkg.sv
// ----------------------------------------------------------------------------
// i2s_stereo_transmitter_pkg
//
// Shared audio definitions for the I2S output stage.
//   AUDIO_WIDTH_DEFAULT : default sample width in bits (two's complement).
//   I2S_DELAY           : Philips I2S one-bit delay between a word-select
//                         change and the MSB of the new word.
//   channel_e           : channel identifier. The encoding matches the
//                         o_lrclk polarity (0 = left slot, 1 = right slot),
//                         so a channel value can drive word select directly.
//   channel_of()        : maps an is_left tag onto a channel_e value.
// ----------------------------------------------------------------------------
package i2s_stereo_transmitter_pkg;

    localparam int AUDIO_WIDTH_DEFAULT = 16;
    localparam int I2S_DELAY           = 1;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } channel_e;

    function automatic channel_e channel_of(input logic is_left);
        return is_left ? CH_LEFT : CH_RIGHT;
    endfunction

endpackage

// File: rtl/i2s_stereo_transmitter_sclk_divider.sv
// ----------------------------------------------------------------------------
// i2s_sclk_divider
//
// Generates the I2S bit clock level from the system clock, plus single-cycle
// strobes that flag the clk edge on which sclk is about to change.
//
// Ports:
//   clk       : system clock, rising-edge logic.
//   reset     : synchronous, active-low reset.
//   sclk      : registered bit clock level (0 out of reset).
//   rise_tick : high during the clk cycle whose closing edge drives sclk 0->1.
//   fall_tick : high during the clk cycle whose closing edge drives sclk 1->0.
//
// Parameter:
//   sclk_div  : clk cycles per sclk half-period (>= 1).
//
// The strobes are combinational look-aheads of the toggle so that logic in
// the same clock domain can update on exactly the edge where sclk changes.
// The first rise lands sclk_div clks after reset release, the first fall
// 2*sclk_div clks after release.
// ----------------------------------------------------------------------------
module i2s_sclk_divider #(
    parameter int sclk_div = 4
) (
    input  logic clk,
    input  logic reset,
    output logic sclk,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int            CW       = (sclk_div > 1) ? $clog2(sclk_div) : 1;
    localparam logic [CW-1:0] TERMINAL = CW'(sclk_div - 1);

    logic [CW-1:0] div_cnt_reg;
    logic          sclk_reg;
    logic          terminal;

    assign terminal  = (div_cnt_reg == TERMINAL);
    assign rise_tick = terminal && !sclk_reg;
    assign fall_tick = terminal &&  sclk_reg;
    assign sclk      = sclk_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_cnt_reg <= '0;
            sclk_reg    <= 1'b0;
        end else if (terminal) begin
            div_cnt_reg <= '0;
            sclk_reg    <= ~sclk_reg;
        end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_stereo_transmitter.sv
// ----------------------------------------------------------------------------
// i2s_stereo_transmitter
//
// Philips I2S master output stage. Accepts an interleaved stereo stream of
// is_left-tagged samples over valid/ready, holds at most one pending sample
// per channel, and transmits continuous frames. A slot whose channel buffer
// is empty at load time carries silence and raises a one-clk underrun pulse.
//
// Parameters:
//   audio_width : bits per sample, MSB first on the wire.
//   slot_width  : sclk cycles per channel slot (>= audio_width+1).
//   sclk_div    : clk cycles per sclk half-period (>= 1).
//
// Ports:
//   clk        : system clock, all logic on the rising edge.
//   reset      : synchronous, active-low reset.
//   i_valid    : input sample valid.
//   i_ready    : input sample accepted when i_valid & i_ready.
//   i_is_left  : 1 = sample belongs to the left channel.
//   i_audio    : sample data.
//   o_sclk     : I2S bit clock.
//   o_lrclk    : I2S word select, 0 = left slot, 1 = right slot.
//   o_sdata    : I2S serial data.
//   o_underrun : one-clk pulse when a slot is loaded from an empty buffer.
//
// Timing model: every data and word-select change happens on the clk edge
// that drives o_sclk 1->0. The bit position counts 0..2*slot_width-1 across
// a frame; the first fall after reset enters position 0 rather than
// advancing, so the first frame begins with a left-slot load.
// ----------------------------------------------------------------------------
module i2s_stereo_transmitter
    import i2s_stereo_transmitter_pkg::*;
#(
    parameter int audio_width = AUDIO_WIDTH_DEFAULT,
    parameter int slot_width  = 32,
    parameter int sclk_div    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_valid,
    output logic                   i_ready,
    input  logic                   i_is_left,
    input  logic [audio_width-1:0] i_audio,
    output logic                   o_sclk,
    output logic                   o_lrclk,
    output logic                   o_sdata,
    output logic                   o_underrun
);

    // ------------------------------------------------------------------
    // Frame position constants
    // ------------------------------------------------------------------
    localparam int            POS_COUNT  = 2 * slot_width;
    localparam int            PW         = $clog2(POS_COUNT);
    localparam logic [PW-1:0] LAST_POS   = PW'(POS_COUNT - 1);
    localparam logic [PW-1:0] SLOT_POS   = PW'(slot_width);
    localparam logic [PW-1:0] DATA_FIRST = PW'(I2S_DELAY);
    localparam logic [PW-1:0] DATA_LAST  = PW'(I2S_DELAY + audio_width - 1);

    // ------------------------------------------------------------------
    // Bit clock
    // ------------------------------------------------------------------
    logic sclk_rise;
    logic sclk_fall;

    i2s_sclk_divider #(
        .sclk_div (sclk_div)
    ) u_sclk_divider (
        .clk       (clk),
        .reset     (reset),
        .sclk      (o_sclk),
        .rise_tick (sclk_rise),
        .fall_tick (sclk_fall)
    );

    // ------------------------------------------------------------------
    // Frame position for the upcoming fall edge
    // ------------------------------------------------------------------
    logic [PW-1:0] pos_reg;
    logic [PW-1:0] pos_next;
    logic          started_reg;
    logic [PW-1:0] slot_pos;
    logic          slot_ch;
    logic          load_tick;

    always_comb begin
        if (!started_reg) begin
            pos_next = '0;
        end else if (pos_reg == LAST_POS) begin
            pos_next = '0;
        end else begin
            pos_next = pos_reg + 1'b1;
        end

        if (pos_next >= SLOT_POS) begin
            slot_ch  = CH_RIGHT;
            slot_pos = pos_next - SLOT_POS;
        end else begin
            slot_ch  = CH_LEFT;
            slot_pos = pos_next;
        end
    end

    assign load_tick = sclk_fall && (slot_pos == '0);

    // ------------------------------------------------------------------
    // Per-channel one-entry buffers
    // ------------------------------------------------------------------
    logic                   in_ch;
    logic [1:0]             full_vec;
    logic [audio_width-1:0] buf_arr [2];

    assign in_ch   = channel_of(i_is_left);
    // i_is_left is treated as data: ready reflects the addressed buffer only.
    assign i_ready = !full_vec[in_ch];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            logic                   full_reg;
            logic [audio_width-1:0] buf_reg;
            logic                   wr_en;
            logic                   ld_en;

            assign wr_en = i_valid && i_ready && (in_ch == 1'(gi));
            assign ld_en = load_tick && (slot_ch == 1'(gi));

            // A load and a write on the same edge can only coincide when
            // the buffer is empty (ready is low while full), so the write
            // simply wins and the new sample waits for the next frame.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    full_reg <= 1'b0;
                    buf_reg  <= '0;
                end else begin
                    if (ld_en) begin
                        full_reg <= 1'b0;
                    end
                    if (wr_en) begin
                        full_reg <= 1'b1;
                        buf_reg  <= i_audio;
                    end
                end
            end

            assign full_vec[gi] = full_reg;
            assign buf_arr[gi]  = buf_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Serializer: word select, shift register, data and underrun flag
    // ------------------------------------------------------------------
    logic [audio_width-1:0] shift_reg;
    logic                   lrclk_reg;
    logic                   sdata_reg;
    logic                   underrun_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pos_reg      <= '0;
            started_reg  <= 1'b0;
            shift_reg    <= '0;
            lrclk_reg    <= 1'b0;
            sdata_reg    <= 1'b0;
            underrun_reg <= 1'b0;
        end else begin
            underrun_reg <= 1'b0;
            if (sclk_fall) begin
                started_reg <= 1'b1;
                pos_reg     <= pos_next;
                if (slot_pos == '0) begin
                    // Slot start: switch word select, fetch the channel's
                    // sample and send the one-bit I2S delay as padding.
                    lrclk_reg <= slot_ch;
                    sdata_reg <= 1'b0;
                    if (full_vec[slot_ch]) begin
                        shift_reg <= buf_arr[slot_ch];
                    end else begin
                        shift_reg    <= '0;
                        underrun_reg <= 1'b1;
                    end
                end else if ((slot_pos >= DATA_FIRST) && (slot_pos <= DATA_LAST)) begin
                    sdata_reg <= shift_reg[audio_width-1];
                    shift_reg <= shift_reg << 1;
                end else begin
                    sdata_reg <= 1'b0;
                end
            end
        end
    end

    assign o_lrclk    = lrclk_reg;
    assign o_sdata    = sdata_reg;
    assign o_underrun = underrun_reg;

    // The divider can never announce a rise and a fall for the same edge.
    sclk_strobe_exclusive: assert property (
        @(posedge clk) disable iff (!reset) !(sclk_rise && sclk_fall)
    );

endmodule
